serial_subdecrement: RTL
========================

Name: serial_subdecrement

Overview:
- Bit-serial subtract-and-decrement unit: computes R = A - B - 1 (mod 2^WIDTH), one bit per clock, LSB first.
- It is the inverse-direction companion to the team's combinational add-increment cell, for area-constrained ALU paths.
- Sits behind the ALU operand registers with a start/done handshake.
- Exports a borrow flag and a zero flag.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
a  in  WIDTH  minuend; sampled on the accepted start edge
b  in  WIDTH  subtrahend; sampled on the accepted start edge
busy  out  1  high while a computation is in progress (SHIFT state)
done  out  1  one-cycle pulse; result/flags valid from this cycle
result  out  WIDTH  A - B - 1 mod 2^WIDTH; held until next completion
borrow_out  out  1  final borrow; 1 iff A <= B (unsigned)
zero  out  1  1 iff result == 0

Behaviour:
- One clock; reset is asynchronous and active-low. rst_n low forces:
  - state to IDLE
  - busy, done, borrow_out, zero, result, internal shift registers, counter and borrow to 0
- This applies immediately, including mid-computation. No partial result survives reset.
- FSM states are IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: capture a and b into shift registers, set running borrow to 1 (this implements the decrement), clear the counter, go to SHIFT.
  - With start=0: stay in IDLE; outputs hold.
- SHIFT:
  - busy=1. Each edge consumes bit 0 of each operand shift register (ai, bi) with running borrow br:
    - d = ai ^ bi ^ br
    - br' = (~ai & bi) | (~ai & br) | (bi & br)
  - Shift d into the MSB of the result shift register. Shift both operand registers right by 1. Increment the counter.
  - On the edge where the counter reaches WIDTH-1 (the WIDTH-th bit edge):
    - load result from the completed shift value
    - load borrow_out from the final br'
    - set zero = (completed value == 0)
    - go to DONE
- DONE: busy=0, done=1 for exactly this cycle. Next edge goes unconditionally to IDLE. start in DONE is ignored.
- Latency: if start is sampled at edge k, done is high in the cycle after edge k+WIDTH. A new start is accepted no earlier than edge k+WIDTH+2.
- start while busy or in DONE: ignored; no queuing, no error flag.
- a and b may change freely after the accepted edge; they are not re-sampled.
- result, borrow_out and zero change only on the completion edge. They are stable through IDLE and SHIFT of the following operation.
- Arithmetic is unsigned modulo 2^WIDTH. Wrap-around examples: A=0, B=0 gives all-ones with borrow_out=1; A=B gives all-ones with borrow_out=1.

Decomposition:
- Package alu_serial_pkg: state enum (IDLE, SHIFT, DONE) and the constant INIT_BORROW = 1'b1.
- One natural sub-module: full_subtractor_bit (ai, bi, bin -> d, bout), purely combinational. It mirrors the team's add-increment cell, instantiated once, with the running borrow in a flop in the parent.
- Counter, shift registers and FSM stay in the top module.

Test Plan:
1. Reset mid-run: start with A=8'h10, B=8'h05; pull rst_n low at the 3rd SHIFT edge -> busy=0, done=0, result=0, borrow_out=0, zero=0 immediately. A fresh start then completes normally.
2. Basic: A=8'h10, B=8'h05 -> done exactly 8 cycles after start edge; result=8'h0A, borrow_out=0, zero=0. busy high for 8 cycles.
3. Wrap/borrow: A=8'h05, B=8'h05 -> result=8'hFF, borrow_out=1, zero=0. Also A=8'h00, B=8'h00 -> 8'hFF, borrow_out=1. Also A=8'h00, B=8'hFF -> 8'h00, borrow_out=1, zero=1.
4. Zero flag: A=8'h01, B=8'h00 -> result=8'h00, zero=1, borrow_out=0. Also A=8'hFF, B=8'h00 -> 8'hFE, zero=0, borrow_out=0.
5. Handshake: hold start=1 continuously and change a/b every cycle after acceptance -> exactly one operation per IDLE visit, done pulses every WIDTH+2 cycles, result uses only the values captured at acceptance. Result holds between dones.
6. Parameter sweep: WIDTH=2 and WIDTH=16 with random operands (≥1000 each) against the reference model (A-B-1) mod 2^WIDTH, borrow=(A<=B) -> zero mismatches; latency = WIDTH.

Source files
------------

// File: rtl/alu_serial_pkg.sv
// Shared types for the bit-serial subtract-decrement unit.
// FSM state encoding and the borrow seed that performs the -1.
package alu_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic INIT_BORROW = 1'b1;

endpackage

// File: rtl/serial_subdecrement_if.sv
// Start/done handshake and operand/result bus
// for the serial subtract-decrement unit.
interface serial_subdecrement_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             borrow_out;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, result, borrow_out, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, borrow_out, zero
    );
endinterface

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = ai - bi - bin, with borrow out.
// Combinational mirror of the add-increment cell.
module full_subtractor_bit (
    input  logic ai,
    input  logic bi,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = ai ^ bi ^ bin;
    assign bout = (~ai & bi) | (~ai & bin) | (bi & bin);
endmodule

// File: rtl/serial_subdecrement.sv
// Bit-serial R = A - B - 1, LSB first, one bit per clock.
// Exports final borrow (A <= B) and a zero flag.
module serial_subdecrement
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    serial_subdecrement_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             borrow_q;
    logic             zero_q;
    logic             d;
    logic             bout;
    logic [WIDTH-1:0] r_next;
    logic             last;

    full_subtractor_bit u_fs (
        .ai   (a_sr[0]),
        .bi   (b_sr[0]),
        .bin  (br),
        .d    (d),
        .bout (bout)
    );

    assign r_next = {d, r_sr[WIDTH-1:1]};
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            r_sr     <= '0;
            result_q <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        br    <= INIT_BORROW;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_sr <= r_next;
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= bout;
                    cnt  <= cnt + CNT_W'(1);
                    // Last bit: publish the assembled word and flags.
                    if (last) begin
                        result_q <= r_next;
                        borrow_q <= bout;
                        zero_q   <= (r_next == '0);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = (state == SHIFT);
    assign bus.done       = (state == DONE);
    assign bus.result     = result_q;
    assign bus.borrow_out = borrow_q;
    assign bus.zero       = zero_q;
endmodule
